// File: rtl/data_mem_responder.sv
// Single-port data RAM behind a valid/ready request/response pair.
// Handles RV32I load/store sizes, sign extension and fault detection.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h80000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic [31:0]   rd_word;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          illegal;
    logic          misalign;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ext;

    // Below-base addresses wrap to huge offsets, so one compare covers both ends.
    assign off      = addr_q - BASE_ADDR;
    assign in_range = off < SPAN;
    assign idx      = off[AW+1:2];
    assign illegal  = wr_q ? (f3_q[2] || f3_q[1:0] == 2'b11)
                           : (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111);
    assign misalign = (f3_q[1:0] == 2'b01 && addr_q[0])
                   || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    assign fault    = !in_range || illegal || misalign;

    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                wlane = {4{wdata_q[7:0]}};
                be    = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                wlane = {2{wdata_q[15:0]}};
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        lane_b = rd_word[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (f3_q)
            3'b000:  ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ext = {24'h0, lane_b};
            3'b101:  ext = {16'h0, lane_h};
            default: ext = rd_word;
        endcase
    end

    // RAM is never cleared; a store reaching ACCESS commits even under reset.
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            rd_word <= mem[idx];
            if (wr_q && !fault) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        f3_q      <= req_funct3;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ACCESS: state <= RESP;
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_fault <= fault;
                        resp_rdata <= (fault || wr_q) ? 32'h0 : ext;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_fault <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder.
// Table of load/store vectors plus stall and reset-in-flight sequences.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          fault;
        string       name;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic drive(input bit wr, input logic [31:0] a,
                         input logic [2:0] f, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_funct3 = f;
        req_wdata  = d;
    endtask

    task automatic idle_bus();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
    endtask

    // Full transaction with latency, data and return-to-ready checks.
    task automatic do_req(input vec_t v);
        wait_ready(v.name);
        drive(v.wr, v.addr, v.f3, v.wdata);
        tick();
        idle_bus();
        chk({v.name, "_lat1"}, {31'h0, resp_valid}, 32'h0);
        tick();
        chk({v.name, "_lat2"}, {31'h0, resp_valid}, 32'h0);
        tick();
        chk({v.name, "_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({v.name, "_rdata"}, resp_rdata, v.exp);
        chk({v.name, "_fault"}, {31'h0, resp_fault}, {31'h0, v.fault});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({v.name, "_done"}, {30'h0, resp_valid, req_ready}, 32'h0);
        tick();
        chk({v.name, "_rdy"}, {31'h0, req_ready}, 32'h1);
    endtask

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [2:0] f,
                                logic [31:0] d, logic [31:0] e, bit flt,
                                string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.f3 = f; v.wdata = d;
        v.exp = e; v.fault = flt; v.name = n;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 32'h80000010, 3'b010, 32'hDEADBEEF, 0, 0, "sw_dead");
        vecs[1]  = mk(0, 32'h80000010, 3'b010, 0, 32'hDEADBEEF, 0, "lw_dead");
        vecs[2]  = mk(1, 32'h80000013, 3'b000, 32'h00000080, 0, 0, "sb_80");
        vecs[3]  = mk(0, 32'h80000013, 3'b000, 0, 32'hFFFFFF80, 0, "lb_80");
        vecs[4]  = mk(0, 32'h80000013, 3'b100, 0, 32'h00000080, 0, "lbu_80");
        vecs[5]  = mk(0, 32'h80000010, 3'b010, 0, 32'h80ADBEEF, 0, "lw_merged");
        vecs[6]  = mk(0, 32'h80000012, 3'b010, 0, 0, 1, "lw_misal");
        vecs[7]  = mk(1, 32'h80000011, 3'b001, 32'h1234, 0, 1, "sh_misal");
        vecs[8]  = mk(0, 32'h80000010, 3'b010, 0, 32'h80ADBEEF, 0, "lw_unchg");
        vecs[9]  = mk(0, 32'h7FFFFFFC, 3'b010, 0, 0, 1, "lw_below");
        vecs[10] = mk(0, 32'h80004000, 3'b010, 0, 0, 1, "lw_above");
        vecs[11] = mk(0, 32'h80000010, 3'b011, 0, 0, 1, "ld_f3_011");
        vecs[12] = mk(0, 32'h80000012, 3'b001, 0, 32'hFFFF80AD, 0, "lh_hi");
        vecs[13] = mk(0, 32'h80000010, 3'b101, 0, 32'h0000BEEF, 0, "lhu_lo");
        vecs[14] = mk(1, 32'h80000014, 3'b010, 32'h11223344, 0, 0, "sw_14");
        vecs[15] = mk(1, 32'h80000016, 3'b001, 32'hAAAA9876, 0, 0, "sh_16");
        vecs[16] = mk(0, 32'h80000014, 3'b010, 0, 32'h98763344, 0, "lw_14");
        vecs[17] = mk(1, 32'h80000014, 3'b100, 32'h0, 0, 1, "st_f3_100");
        vecs[18] = mk(1, 32'h80003FFC, 3'b010, 32'h12345678, 0, 0, "sw_last");
        vecs[19] = mk(0, 32'h80003FFC, 3'b010, 0, 32'h12345678, 0, "lw_last");

        idle_bus();
        resp_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_fault", {31'h0, resp_fault}, 32'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 20; i++) do_req(vecs[i]);

        // Response stall: outputs hold and a stray request is ignored.
        wait_ready("stall");
        drive(0, 32'h80000010, 3'b010, 0);
        tick();
        idle_bus();
        tick();
        tick();
        chk("stall_valid", {31'h0, resp_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1, 32'h80000010, 3'b010, 32'h0);
            tick();
            idle_bus();
            chk("stall_hold", {resp_valid, resp_fault, req_ready, 29'h0},
                {3'b100, 29'h0});
            chk("stall_rdata", resp_rdata, 32'h80ADBEEF);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("stall_done", {30'h0, resp_valid, req_ready}, 32'h0);
        tick();
        chk("stall_rdy", {31'h0, req_ready}, 32'h1);
        do_req(mk(0, 32'h80000010, 3'b010, 0, 32'h80ADBEEF, 0, "lw_after_stall"));

        // Reset while a store is in ACCESS: response dropped, store kept.
        wait_ready("rst_fl");
        drive(1, 32'h80000020, 3'b010, 32'hCAFEF00D);
        tick();
        idle_bus();
        reset = 1'b1;
        tick();
        chk("rst_fl_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_fl_ready", {31'h0, req_ready}, 32'h0);
        reset = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_fl_noresp", {31'h0, resp_valid}, 32'h0);
        end
        resp_ready = 1'b0;
        chk("rst_fl_rdy", {31'h0, req_ready}, 32'h1);
        do_req(mk(0, 32'h80000020, 3'b010, 0, 32'hCAFEF00D, 0, "lw_after_rst"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
